// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (RV32M DIV/DIVU/REM/REMU) feeding the register file write port.
// Optional macro DIV_SIGNED_EN enables signed DIV/REM; otherwise op[0] is ignored and all ops are unsigned.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        kill,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        result_we,
    output logic [4:0]  rd_out,
    output logic [31:0] result,
    output logic [1:0]  dbg_state
);

    // Handshake: start is accepted only on an edge where the unit is IDLE; busy is high
    // from that edge until the edge after result_we, and result_we pulses for exactly one cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_op_rem;
    logic [4:0]  r_rd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [5:0]  r_cnt;
    logic        r_dvz;

    logic [31:0] w_a_in;
    logic [31:0] w_b_in;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [31:0] w_res;

`ifdef DIV_SIGNED_EN
    logic        r_qneg;
    logic        r_rneg;
    logic        r_ovf;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_ovf_in;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & dividend[31];
    assign w_b_neg  = w_signed & divisor[31];
    assign w_a_in   = w_a_neg ? (32'd0 - dividend) : dividend;
    assign w_b_in   = w_b_neg ? (32'd0 - divisor) : divisor;
    assign w_ovf_in = w_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
    assign w_q_fix  = r_qneg ? (32'd0 - r_quo) : r_quo;
    assign w_r_fix  = r_rneg ? (32'd0 - r_rem) : r_rem;
`else
    logic        w_unused_op0;

    assign w_unused_op0 = op[0];
    assign w_a_in       = dividend;
    assign w_b_in       = divisor;
    assign w_q_fix      = r_quo;
    assign w_r_fix      = r_rem;
`endif

    // The shifted remainder can need 33 bits when the divisor is >= 2^31, so the
    // trial subtraction keeps a spare bit and the borrow lands in bit 33.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    assign w_ge     = ~w_diff[33];

    always_comb begin
        w_res = r_op_rem ? w_r_fix : w_q_fix;
        if (r_dvz && !r_op_rem) begin
            w_res = 32'hFFFF_FFFF;
        end
`ifdef DIV_SIGNED_EN
        if (r_ovf) begin
            w_res = r_op_rem ? 32'd0 : 32'h8000_0000;
        end
`endif
    end

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op_rem  <= 1'b0;
            r_rd      <= 5'd0;
            r_dvs     <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_cnt     <= 6'd0;
            r_dvz     <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_ovf     <= 1'b0;
`endif
            busy      <= 1'b0;
            result_we <= 1'b0;
            rd_out    <= 5'd0;
            result    <= 32'd0;
        end else if (kill && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            result_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    result_we <= 1'b0;
                    if (start) begin
                        r_state  <= S_CALC;
                        busy     <= 1'b1;
                        r_op_rem <= op[1];
                        r_rd     <= rd_in;
                        r_quo    <= w_a_in;
                        r_dvs    <= w_b_in;
                        r_rem    <= 32'd0;
                        r_cnt    <= 6'd32;
                        r_dvz    <= (divisor == 32'd0);
`ifdef DIV_SIGNED_EN
                        r_qneg   <= w_a_neg ^ w_b_neg;
                        r_rneg   <= w_a_neg;
                        r_ovf    <= w_ovf_in;
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result    <= w_res;
                    rd_out    <= r_rd;
                    result_we <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    result_we <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver tasks push {cycle, rd, result} expectations; a negedge monitor checks each write pulse.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_in;
    logic        busy;
    logic        result_we;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int unsigned cyc;
    int unsigned last_c0;
    int          total;
    int          bad;
    logic [68:0] exp_q[$];

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .kill      (kill),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .rd_in     (rd_in),
        .busy      (busy),
        .result_we (result_we),
        .rd_out    (rd_out),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: issue one operation; optionally push its expected write
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input bit push);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        rd_in    = rd;
        @(posedge clk);
        #1;
        last_c0 = cyc;
        if (push) exp_q.push_back({32'(last_c0 + 33), rd, exp_res});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 45) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        int n;
        n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
        issue(o, a, b, rd, exp_res, 1'b1);
        wait_idle("op_done");
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && result_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: pulse at cycle %0d rd=%0d result=0x%08h, required none",
                         cyc, rd_out, result);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                total++;
                if (cyc !== e[68:37] || rd_out !== e[36:32] || result !== e[31:0]) begin
                    bad++;
                    $display("FAIL write: got cyc=%0d rd=%0d res=0x%08h expected cyc=%0d rd=%0d res=0x%08h",
                             cyc, rd_out, result, e[68:37], e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        kill     = 1'b0;
        op       = 2'b00;
        dividend = 32'd0;
        divisor  = 32'd0;
        rd_in    = 5'd0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_we", {31'd0, result_we}, 32'd0);
        chk("reset_rd", {27'd0, rd_out}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
        run(OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2);
`ifdef DIV_SIGNED_EN
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
        run(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2);
        run(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'd2);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
        run(OP_REM, 32'h8000_0001, 32'd0, 5'd10, 32'h8000_0001);
`else
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'd1);
        run(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'd0);
        run(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'd100);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
        run(OP_REM, 32'h8000_0001, 32'd0, 5'd10, 32'h8000_0001);
`endif
        run(OP_DIVU, 32'h1234_5678, 32'd0, 5'd11, 32'hFFFF_FFFF);
        run(OP_REMU, 32'h1234_5678, 32'd0, 5'd11, 32'h1234_5678);
        run(OP_DIV, 32'h1234_5678, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, 32'd1);
        run(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd13, 32'h7FFF_FFFF);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF);

        // start while busy and in the DONE cycle must be ignored
        issue(OP_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 1'b1);
        wait_cyc(last_c0 + 9);
        start = 1'b1; op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd15;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!result_we && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b1; rd_in = 5'd16;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // kill mid-operation, then restart immediately
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd17, 32'd0, 1'b0);
        wait_cyc(last_c0 + 19);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        run(OP_REMU, 32'd1000, 32'd3, 5'd18, 32'd1);

        // async reset mid-operation
        issue(OP_DIVU, 32'd77, 32'd7, 5'd19, 32'd0, 1'b0);
        wait_cyc(last_c0 + 14);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(OP_DIVU, 32'd9, 32'd3, 5'd20, 32'd3);
        repeat (40) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
